// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED PIO sequencer: pattern modes, FSM states and
// the PIO data register address.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SHIFT = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;

endpackage

// File: rtl/led_pio_sequencer_if.sv
// Avalon-MM write bundle between the host bridge, the sequencer and the LED PIO.
// The master modport is the sequencer's view: it receives host write-through
// requests and drives the PIO s1 port. The slave modport is the opposite side.
interface led_pio_sequencer_if;

    logic        host_chipselect;
    logic        host_write_n;
    logic [1:0]  host_address;
    logic [31:0] host_writedata;

    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;

    modport master (
        input  host_chipselect, host_write_n, host_address, host_writedata,
        output pio_address, pio_chipselect, pio_write_n, pio_writedata
    );

    modport slave (
        output host_chipselect, host_write_n, host_address, host_writedata,
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata
    );

endinterface

// File: rtl/led_step_timer.sv
// Step-rate divider: counts cycles while running and pulses step for one cycle
// every max(step_div,1) cycles. step_div is read live; the terminal test is an
// equality, so a value lowered below the current count only hits after wrap.
module led_step_timer #(
    parameter int unsigned DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clear,
    input  logic [DIV_W-1:0] step_div,
    output logic             step
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] last_cnt;
    logic             term;

    // Next count and step pulse from the live divider value.
    always_comb begin
        last_cnt  = (step_div == '0) ? '0 : step_div - DIV_W'(1);
        term      = (div_cnt_q == last_cnt);
        step      = run & ~clear & term;
        div_cnt_d = div_cnt_q;
        if (clear) begin
            div_cnt_d = '0;
        end else if (run) begin
            div_cnt_d = term ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    // Divider counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/led_pio_sequencer.sv
// Avalon-MM master for the LED PIO: steps a count/shift/blink pattern at a
// programmable rate and arbitrates the PIO between that engine and a host
// write-through port. The host always wins; a deferred sequencer write is
// coalesced so only the latest pattern is written once the host releases.
module led_pio_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned LED_W = 4,
    parameter int unsigned DIV_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [DIV_W-1:0]    step_div,
    led_pio_sequencer_if.master bus,
    output logic                seq_active,
    output logic [15:0]         step_count
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [LED_W-1:0]   pat_q, pat_d;
    logic               pending_q, pending_d;
    logic [15:0]        step_count_q, step_count_d;
    logic [1:0]         pio_address_q, pio_address_d;
    logic               pio_chipselect_q, pio_chipselect_d;
    logic               pio_write_n_q, pio_write_n_d;
    logic [31:0]        pio_writedata_q, pio_writedata_d;
    logic               seq_active_q, seq_active_d;

    logic               start, stop, run, step;
    logic               host_req, seq_req;
    logic [LED_W-1:0]   pat_init, pat_next;

    assign start = (state_q == ST_IDLE) &  enable;
    assign stop  = (state_q == ST_RUN)  & ~enable;
    assign run   = (state_q == ST_RUN)  &  enable;

    led_step_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .clear    (start | stop),
        .step_div (step_div),
        .step     (step)
    );

    // Pattern seed for the requested mode and the next pattern for the latched mode.
    always_comb begin
        case (mode_e'(mode))
            MODE_SHIFT: pat_init = LED_W'(1);
            MODE_BLINK: pat_init = '1;
            default:    pat_init = '0;
        endcase
        case (mode_q)
            MODE_SHIFT: pat_next = (pat_q << 1) | (pat_q >> (LED_W - 1));
            MODE_BLINK: pat_next = ~pat_q;
            default:    pat_next = pat_q + LED_W'(1);
        endcase
    end

    // Arbitration mux plus FSM next-state; the stop cycle suppresses any pending write.
    always_comb begin
        state_d          = state_q;
        mode_d           = mode_q;
        pat_d            = pat_q;
        pending_d        = pending_q;
        step_count_d     = step_count_q;
        pio_address_d    = pio_address_q;
        pio_writedata_d  = pio_writedata_q;
        pio_chipselect_d = 1'b0;
        pio_write_n_d    = 1'b1;

        host_req = bus.host_chipselect & ~bus.host_write_n;
        seq_req  = run & pending_q;

        if (host_req) begin
            pio_address_d    = bus.host_address;
            pio_writedata_d  = bus.host_writedata;
            pio_chipselect_d = 1'b1;
            pio_write_n_d    = 1'b0;
        end else if (seq_req) begin
            pio_address_d               = PIO_ADDR_DATA;
            pio_writedata_d             = '0;
            pio_writedata_d[LED_W-1:0]  = pat_q;
            pio_chipselect_d            = 1'b1;
            pio_write_n_d               = 1'b0;
            pending_d                   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d      = ST_RUN;
                    mode_d       = mode_e'(mode);
                    pat_d        = pat_init;
                    pending_d    = 1'b1;
                    step_count_d = '0;
                end
            end
            default: begin
                if (!enable) begin
                    state_d   = ST_IDLE;
                    pending_d = 1'b0;
                end else if (step) begin
                    pat_d        = pat_next;
                    pending_d    = 1'b1;
                    step_count_d = step_count_q + 16'd1;
                end
            end
        endcase

        seq_active_d = (state_d == ST_RUN);
    end

    // FSM, pattern and registered bus/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            mode_q           <= MODE_COUNT;
            pat_q            <= '0;
            pending_q        <= 1'b0;
            step_count_q     <= '0;
            pio_address_q    <= '0;
            pio_chipselect_q <= 1'b0;
            pio_write_n_q    <= 1'b1;
            pio_writedata_q  <= '0;
            seq_active_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            mode_q           <= mode_d;
            pat_q            <= pat_d;
            pending_q        <= pending_d;
            step_count_q     <= step_count_d;
            pio_address_q    <= pio_address_d;
            pio_chipselect_q <= pio_chipselect_d;
            pio_write_n_q    <= pio_write_n_d;
            pio_writedata_q  <= pio_writedata_d;
            seq_active_q     <= seq_active_d;
        end
    end

    assign bus.pio_address    = pio_address_q;
    assign bus.pio_chipselect = pio_chipselect_q;
    assign bus.pio_write_n    = pio_write_n_q;
    assign bus.pio_writedata  = pio_writedata_q;
    assign seq_active         = seq_active_q;
    assign step_count         = step_count_q;

endmodule
